alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-side controller that drives the 8-bit ALU and consumes its result and zero flag.
- Accepts 9-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 8x8 register file.
- Presents the operands to the external ALU, captures result/zero, writes back to the destination register and signals completion.
- Sits between instruction fetch and the ALU instance in the pebble datapath.

Parameters:
- NREGS, 8, number of architectural registers; must be a power of two.
- W, 8, data width; must match the ALU width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present
- in_instr  in  9  [8:6] op, [5:3] rd (also source A), [2:0] rs (source B)
- in_ready  out  1  block can accept an instruction this cycle
- ld_valid  in  1  external register load strobe (initialisation/test)
- ld_addr  in  3  load target register
- ld_data  in  W  load value
- alu_op  out  3  operation code to ALU
- alu_a  out  W  ALU operand r0
- alu_b  out  W  ALU operand r1
- alu_result  in  W  ALU result (combinational from alu_op/alu_a/alu_b)
- alu_zero  in  1  ALU zero flag
- done  out  1  one-cycle completion pulse
- done_data  out  W  value written back, valid while done=1
- zero_flag  out  1  sticky copy of the ALU zero flag from the last completed instruction
- dbg_addr  in  3  debug register read address
- dbg_data  out  W  combinational read of regfile[dbg_addr]

Behaviour:
- Op encoding passed through unchanged: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl (r0<<1), 110 shr (r0>>1), 111 signed slt.
- Reset (asynchronous, active-high; takes effect immediately, including mid-instruction):
  - state=IDLE; all regfile entries 0.
  - alu_op=0, alu_a=0, alu_b=0, done=0, done_data=0, zero_flag=0.
  - An in-flight instruction is discarded with no writeback and no done.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready = !ld_valid.
    - If ld_valid: regfile[ld_addr] <= ld_data.
    - Else if in_valid: latch op, rd, rs; latch A=regfile[rd] and B=regfile[rs]; go to EXEC.
    - ld_valid therefore always has priority over an instruction in the same cycle.
  - EXEC: alu_op/alu_a/alu_b are driven from the latched registers (registered outputs, stable for the whole cycle); capture alu_result and alu_zero into internal registers; go to WB. in_ready=0; ld_valid is ignored.
  - WB: regfile[rd] <= captured result; done=1; done_data=result; zero_flag <= captured zero; go to IDLE. in_ready=0; ld_valid is ignored.
- Latency and throughput:
  - Handshake at cycle T (rising edge closing T).
  - ALU operands valid during T+1; done asserted during T+2; regfile visible on dbg_data from T+3.
  - in_ready high again at T+3. Maximum throughput is one instruction per 3 cycles.
- Operand and register rules:
  - alu_a/alu_b hold their last values outside EXEC; no requirement to zero them.
  - rd==rs is legal: both operands read the same register. Example: xor r2,r2 clears r2 and sets zero_flag=1.
  - A back-to-back dependent instruction reads the written-back value, because writeback completes before the next acceptance.
- Width rules: all arithmetic is modulo 2^W inside the ALU. This block performs no extension, saturation or carry tracking.
- Shift ops: alu_b is still driven with regfile[rs], but its value is irrelevant.
- zero_flag changes only in WB (or on reset).

Decomposition:
- Shared package pebble_pkg:
  - typedef alu_op_t (3-bit enum: ADD, SUB, AND, OR, XOR, SHL, SHR, SLT).
  - instruction field positions and widths.
  - typedef issue_state_t {IDLE, EXEC, WB}.
  - The ALU is updated to use alu_op_t from the package.
- One natural sub-module: regfile8 (NREGS x W).
  - Async-reset storage, one synchronous write port, three combinational read ports (A, B, dbg).
  - The write mux between the ld port and writeback lives in alu_issue.

Test Plan:
- Reset mid-EXEC: load r1=5, issue add r1,r1, assert reset during EXEC -> done never pulses, in_ready=1 after release, dbg r1=0, zero_flag=0.
- Load r1=0x05, r2=0x03; issue add r1,r2 (9'b000_001_010) -> alu_a=5, alu_b=3 at T+1; done=1, done_data=0x08 at T+2; dbg r1=0x08 at T+3; zero_flag=0.
- Load r3=0x80, r4=0x01; issue slt r3,r4 -> done_data=0x01 (signed -128<1); then sub r4,r4 -> done_data=0x00, zero_flag=1.
- Wrap-around: r5=0xFF, r6=0x01, add -> 0x00 with zero_flag=1; then shl r5 with r5=0x81 -> 0x02; shr r5 with r5=0x81 -> 0x40.
- Priority: ld_valid=1 (r0<=0x22) and in_valid=1 in the same IDLE cycle -> in_ready=0, load happens, instruction is accepted on the next cycle once ld_valid drops. ld_valid held during EXEC/WB -> regfile unchanged.
- Back-to-back with in_valid held high: xor r2,r2 then or r2,r1 (r1=0x0C) -> first done_data=0x00 with zero_flag=1; second done_data=0x0C with zero_flag=0. Done pulses are exactly 3 cycles apart.

Source files
------------

// File: rtl/pebble_pkg.sv
// Shared types for the pebble execute path: ALU op codes, issue FSM states
// and the field layout of the 9-bit register-register instruction.
package pebble_pkg;

  localparam int INSTR_W = 9;
  localparam int REG_AW  = 3;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int RS_LSB  = 0;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [REG_AW-1:0]  reg_addr_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;

  function automatic alu_op_t instr_op(instr_t i);
    return alu_op_t'(i[OP_LSB +: 3]);
  endfunction

  function automatic reg_addr_t instr_rd(instr_t i);
    return i[RD_LSB +: REG_AW];
  endfunction

  function automatic reg_addr_t instr_rs(instr_t i);
    return i[RS_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU operand/result bus and completion signals
// between fetch, the issue controller and the external ALU.
interface alu_issue_if
  import pebble_pkg::*;
#(
  parameter int W = 8
) ();

  logic          in_valid;
  instr_t        in_instr;
  logic          in_ready;
  alu_op_t       alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          done;
  logic [W-1:0]  done_data;

  modport slave (
    input  in_valid, in_instr, alu_result, alu_zero,
    output in_ready, alu_op, alu_a, alu_b, done, done_data
  );

  modport master (
    output in_valid, in_instr, alu_result, alu_zero,
    input  in_ready, alu_op, alu_a, alu_b, done, done_data
  );

endinterface

// File: rtl/alu_issue_regfile8.sv
// NREGS x W register file: async-reset storage, one synchronous write port,
// three combinational read ports (operand A, operand B, debug).
module regfile8 #(
  parameter int NREGS = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] raddr_d,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b,
  output logic [W-1:0]  rdata_d
);

  logic [W-1:0] mem_q [NREGS];
  logic [W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
  assign rdata_d = mem_q[raddr_d];

endmodule

// File: rtl/alu_issue.sv
// Execute-side issue controller: reads operands, drives the external ALU,
// captures its result and writes it back, one instruction every three cycles.
module alu_issue
  import pebble_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_issue_if.slave   bus,
  input  logic         ld_valid,
  input  reg_addr_t    ld_addr,
  input  logic [W-1:0] ld_data,
  output logic         zero_flag,
  input  reg_addr_t    dbg_addr,
  output logic [W-1:0] dbg_data
);

  issue_state_t state_q, state_d;
  alu_op_t      op_q, op_d;
  reg_addr_t    rd_q, rd_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic         zcap_q, zcap_d, zf_q, zf_d;

  logic         in_ready;
  logic         rf_we;
  reg_addr_t    rf_waddr;
  logic [W-1:0] rf_wdata, rf_a, rf_b;

  regfile8 #(.NREGS(NREGS), .W(W), .AW(REG_AW)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_rd(bus.in_instr)),
    .raddr_b (instr_rs(bus.in_instr)),
    .raddr_d (dbg_addr),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .rdata_d (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zcap_d   = zcap_q;
    zf_d     = zf_q;
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    case (state_q)
      IDLE: begin
        // A load strobe always wins over an instruction in the same cycle.
        in_ready = !ld_valid;
        if (ld_valid) begin
          rf_we = 1'b1;
        end else if (bus.in_valid) begin
          op_d    = instr_op(bus.in_instr);
          rd_d    = instr_rd(bus.in_instr);
          a_d     = rf_a;
          b_d     = rf_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_result;
        zcap_d  = bus.alu_zero;
        state_d = WB;
      end
      WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res_q;
        zf_d     = zcap_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zcap_q  <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zcap_q  <= zcap_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.done      = (state_q == WB);
  assign bus.done_data = res_q;
  assign zero_flag     = zf_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the bus, register-file model and a
// scoreboard of expected writebacks checked when done pulses.
module tb_alu_issue;
  import pebble_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_valid = 1'b0;
  reg_addr_t  ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       zero_flag;
  reg_addr_t  dbg_addr = '0;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rf_m [8];

  alu_issue_if #(.W(8)) intf ();

  alu_issue #(.NREGS(8), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (intf),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .zero_flag (zero_flag),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << 1;
      3'b110:  return a >> 1;
      default: return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
    endcase
  endfunction

  logic [7:0] alu_r;
  assign alu_r           = ref_alu(intf.alu_op, intf.alu_a, intf.alu_b);
  assign intf.alu_result = alu_r;
  assign intf.alu_zero   = (alu_r == 8'h00);

  task automatic load(input int addr, input logic [7:0] data);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = reg_addr_t'(addr);
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
    rf_m[addr] = data;
  endtask

  // Drives one instruction; returns operands seen in EXEC, done data/time and
  // the zero flag one cycle after done. Returns at T+3.
  task automatic issue(input logic [2:0] op, input int rd, input int rs, input bit hold,
                       output logic [7:0] oa, output logic [7:0] ob, output logic [7:0] od,
                       output logic oz, output time td, output bit to);
    exp_t e;
    int   n;
    e.data = ref_alu(op, rf_m[rd], rf_m[rs]);
    e.zero = (e.data == 8'h00);
    sb.push_back(e);
    rf_m[rd] = e.data;
    to = 1'b0;
    intf.in_valid = 1'b1;
    intf.in_instr = {op, 3'(rd), 3'(rs)};
    #1;
    n = 0;
    while (!intf.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) to = 1'b1;
    @(negedge clk);
    if (!hold) intf.in_valid = 1'b0;
    #1;
    oa = intf.alu_a;
    ob = intf.alu_b;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!intf.done && n < 8);
    if (!intf.done) to = 1'b1;
    od = intf.done_data;
    td = $time;
    @(negedge clk); #1;
    oz = zero_flag;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
    @(negedge clk); #1;
    checks++; if (intf.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", intf.done); end
    checks++; if (intf.done_data !== 8'h00) begin errors++; $display("FAIL reset_done_data: got %h want 00", intf.done_data); end
    checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zf: got %b want 0", zero_flag); end
    checks++; if ({intf.alu_op, intf.alu_a, intf.alu_b} !== 19'h0) begin errors++; $display("FAIL reset_alu_bus: got %h want 0", {intf.alu_op, intf.alu_a, intf.alu_b}); end
    reset = 1'b0;
    #1;
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", intf.in_ready); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = reg_addr_t'(i);
      #1;
      checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_rf%0d: got %h want 00", i, dbg_data); end
    end
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    load(1, 8'h05);
    intf.in_valid = 1'b1;
    intf.in_instr = 9'b000_001_001;
    #1;
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", intf.in_ready); end
    @(negedge clk);
    intf.in_valid = 1'b0;
    #1;
    checks++; if (intf.alu_a !== 8'h05) begin errors++; $display("FAIL rmid_alu_a: got %h want 05", intf.alu_a); end
    reset = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (intf.done) seen = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", seen); end
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", intf.in_ready); end
    dbg_addr = 3'd1; #1;
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL rmid_rf1: got %h want 00", dbg_data); end
    checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL rmid_zf: got %b want 0", zero_flag); end
    for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
  endtask

  task automatic test_add();
    logic [7:0] oa, ob, od; logic oz; time td; bit to; exp_t e;
    load(1, 8'h05);
    load(2, 8'h03);
    dbg_addr = 3'd1;
    issue(3'b000, 1, 2, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL add_timeout: got timeout want done"); end
    checks++; if ({oa, ob} !== 16'h0503) begin errors++; $display("FAIL add_operands: got %h want 0503", {oa, ob}); end
    checks++; if (od !== e.data || od !== 8'h08) begin errors++; $display("FAIL add_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b0) begin errors++; $display("FAIL add_zf: got %b want 0", oz); end
    #1;
    checks++; if (dbg_data !== 8'h08) begin errors++; $display("FAIL add_wb: got %h want 08", dbg_data); end
  endtask

  task automatic test_slt_sub();
    logic [7:0] oa, ob, od; logic oz; time td; bit to; exp_t e;
    load(3, 8'h80);
    load(4, 8'h01);
    issue(3'b111, 3, 4, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h01) begin errors++; $display("FAIL slt_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b0) begin errors++; $display("FAIL slt_zf: got %b want 0", oz); end
    issue(3'b001, 4, 4, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h00) begin errors++; $display("FAIL sub_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b1) begin errors++; $display("FAIL sub_zf: got %b want 1", oz); end
  endtask

  task automatic test_wrap_shift();
    logic [7:0] oa, ob, od; logic oz; time td; bit to; exp_t e;
    load(5, 8'hFF);
    load(6, 8'h01);
    issue(3'b000, 5, 6, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h00) begin errors++; $display("FAIL wrap_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b1) begin errors++; $display("FAIL wrap_zf: got %b want 1", oz); end
    load(5, 8'h81);
    issue(3'b101, 5, 6, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h02) begin errors++; $display("FAIL shl_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b0) begin errors++; $display("FAIL shl_zf: got %b want 0", oz); end
    load(5, 8'h81);
    issue(3'b110, 5, 6, 1'b0, oa, ob, od, oz, td, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h40) begin errors++; $display("FAIL shr_data: got %h want %h", od, e.data); end
  endtask

  task automatic test_priority();
    load(1, 8'h11);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 8'h22;
    intf.in_valid = 1'b1; intf.in_instr = 9'b000_000_001;
    #1;
    checks++; if (intf.in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_ld: got %b want 0", intf.in_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    rf_m[0] = 8'h22;
    #1;
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_after: got %b want 1", intf.in_ready); end
    @(negedge clk);
    intf.in_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 8'h99;
    #1;
    checks++; if ({intf.alu_a, intf.alu_b} !== 16'h2211) begin errors++; $display("FAIL prio_operands: got %h want 2211", {intf.alu_a, intf.alu_b}); end
    checks++; if (intf.in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_exec: got %b want 0", intf.in_ready); end
    @(negedge clk); #1;
    checks++; if (intf.done !== 1'b1 || intf.done_data !== 8'h33) begin errors++; $display("FAIL prio_done: got %b/%h want 1/33", intf.done, intf.done_data); end
    @(negedge clk);
    ld_valid = 1'b0;
    rf_m[0] = 8'h33;
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== rf_m[3]) begin errors++; $display("FAIL prio_ld_ignored: got %h want %h", dbg_data, rf_m[3]); end
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== 8'h33) begin errors++; $display("FAIL prio_wb_r0: got %h want 33", dbg_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa, ob, od; logic oz; time t1, t2; bit to; exp_t e;
    load(1, 8'h0C);
    load(2, 8'h5A);
    issue(3'b100, 2, 2, 1'b1, oa, ob, od, oz, t1, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h00) begin errors++; $display("FAIL b2b_xor_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b1) begin errors++; $display("FAIL b2b_xor_zf: got %b want 1", oz); end
    issue(3'b011, 2, 1, 1'b0, oa, ob, od, oz, t2, to);
    e = sb.pop_front();
    checks++; if (to || od !== e.data || od !== 8'h0C) begin errors++; $display("FAIL b2b_or_data: got %h want %h", od, e.data); end
    checks++; if (oz !== 1'b0) begin errors++; $display("FAIL b2b_or_zf: got %b want 0", oz); end
    checks++; if (t2 - t1 !== 30) begin errors++; $display("FAIL b2b_spacing: got %0t want 30", t2 - t1); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    intf.in_valid = 1'b0;
    intf.in_instr = '0;
    test_reset();
    test_reset_mid_exec();
    test_add();
    test_slt_sub();
    test_wrap_shift();
    test_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
